surf_cout_train_checker: RTL

- Sysclk-domain checker for one SURF COUT lane. Sits between the COUT ISERDES (4 bits per sysclk) and the SURF control register core.
- Finds the nibble-aligned training word in the incoming stream, locks to it, and reports per-cycle bit errors. The register core's bit-error counter consumes these as cout_biterr.
- On a capture request it freezes the last 32 received bits, which the register core returns as COUT data.
- Honours the core's enable and bitslip strobes.

---
 rtl/surf_cout_train_checker.sv | 88 ++++++++
 1 files changed

// File: rtl/surf_cout_train_checker.sv
// surf_cout_train_checker: locks to the COUT training word, flags per-nibble bit errors, captures the last 32 bits
module surf_cout_train_checker #(
  parameter logic [31:0] TRAIN_PATTERN  = 32'hA55A6996,
  parameter int unsigned ERR_LIMIT      = 4,
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rstn_i,
  input  logic [3:0]  cout_i,
  input  logic        enable_i,
  input  logic        capture_i,
  input  logic        bitslip_i,
  output logic [31:0] data_o,
  output logic        biterr_o,
  output logic        locked_o
);
  typedef enum logic [1:0] {IDLE, SEARCH, TRACK, HOLDOFF} state_t;
  state_t      state, state_n;
  logic [31:0] sr, win;
  logic [2:0]  idx, idx_n;
  logic [3:0]  errcnt, errcnt_n, exp_nib;
  logic [7:0]  ho, ho_n;
  logic        biterr_n, locked_n, mismatch, err_hit;
  assign win      = {sr[27:0], cout_i};
  assign exp_nib  = TRAIN_PATTERN[{idx, 2'b11} -: 4];
  assign mismatch = cout_i != exp_nib;
  assign err_hit  = errcnt + 4'd1 == 4'(ERR_LIMIT);
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    errcnt_n = errcnt;
    ho_n     = ho;
    biterr_n = 1'b0;
    locked_n = 1'b0;
    if (!enable_i) state_n = IDLE;
    else if (bitslip_i && state != IDLE) begin
      state_n = HOLDOFF;
      ho_n    = 8'(HOLDOFF_CYCLES - 1);
    end else begin
      case (state)
        IDLE: begin
          state_n  = SEARCH;
          biterr_n = 1'b1;
        end
        SEARCH: begin
          state_n  = win == TRAIN_PATTERN ? TRACK : SEARCH;
          idx_n    = 3'd7;
          errcnt_n = 4'd0;
          biterr_n = win != TRAIN_PATTERN;
          locked_n = win == TRAIN_PATTERN;
        end
        TRACK: begin
          idx_n    = idx - 3'd1;
          biterr_n = mismatch;
          errcnt_n = mismatch && !err_hit ? errcnt + 4'd1 : 4'd0;
          state_n  = mismatch && err_hit ? SEARCH : TRACK;
          locked_n = !(mismatch && err_hit);
        end
        default: begin
          state_n  = ho == 8'd0 ? SEARCH : HOLDOFF;
          ho_n     = ho == 8'd0 ? ho : ho - 8'd1;
          biterr_n = ho == 8'd0;
        end
      endcase
    end
  end
  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      state    <= IDLE;
      sr       <= '0;
      data_o   <= '0;
      biterr_o <= 1'b0;
      locked_o <= 1'b0;
      idx      <= '0;
      errcnt   <= '0;
      ho       <= '0;
    end else begin
      state    <= state_n;
      sr       <= win;
      data_o   <= capture_i ? sr : data_o;
      biterr_o <= biterr_n;
      locked_o <= locked_n;
      idx      <= idx_n;
      errcnt   <= errcnt_n;
      ho       <= ho_n;
    end
  end
endmodule
